// File: rtl/answer_if.sv
// Handshake bundle between the round controller and the random-source / input / display logic.
// The master side drives random words, requests and guesses; the slave side returns the scoring state.
interface answer_if #(
  parameter int N_DIGITS = 4
);
  logic [31:0]           rand_in;
  logic                  new_game;
  logic                  guess_valid;
  logic [4*N_DIGITS-1:0] guess;
  logic                  busy;
  logic [4*N_DIGITS-1:0] answer;
  logic                  answer_valid;
  logic                  fallback;
  logic                  result_valid;
  logic [3:0]            strikes;
  logic [3:0]            balls;
  logic [3:0]            guesses_left;
  logic                  win;
  logic                  game_over;

  modport master (
    output rand_in, new_game, guess_valid, guess,
    input  busy, answer, answer_valid, fallback, result_valid,
           strikes, balls, guesses_left, win, game_over
  );

  modport slave (
    input  rand_in, new_game, guess_valid, guess,
    output busy, answer, answer_valid, fallback, result_valid,
           strikes, balls, guesses_left, win, game_over
  );
endinterface

// File: rtl/answer_ctrl.sv
// Number-guessing round controller: draws a legal answer from a free-running random word,
// then scores each guess digit-serially into strikes/balls and tracks win / game over.
module answer_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int MAX_TRIES   = 16,
  parameter int MAX_GUESSES = 10
) (
  input  logic     clk,
  input  logic     rst,
  answer_if.slave  bus
);

  localparam int              W           = 4 * N_DIGITS;
  localparam int              IDX_W       = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [3:0]      ALL_STRIKES = 4'(N_DIGITS);
  localparam logic [7:0]      TRY_LIMIT   = 8'(MAX_TRIES);
  localparam logic [3:0]      GUESS_LIMIT = 4'(MAX_GUESSES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_CHECK,
    S_READY,
    S_SCORE,
    S_RESULT,
    S_DONE
  } state_t;

  state_t            state;
  logic [7:0]        tries;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      cand;
  logic [W-1:0]      g;
  logic [W-1:0]      answer_q;
  logic              fallback_q;
  logic              result_valid_q;
  logic [3:0]        strikes_q;
  logic [3:0]        balls_q;
  logic [3:0]        guesses_left_q;
  logic              win_q;
  logic              game_over_q;

  // Only the low W bits of the random word are ever sampled.
  logic unused_rand;
  assign unused_rand = ^bus.rand_in;

  function automatic logic is_legal(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] == 4'd0 || v[4*i +: 4] > 4'd8) ok = 1'b0;
      for (int j = i + 1; j < N_DIGITS; j++) begin
        if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [W-1:0] default_answer();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N_DIGITS; i++) r[4*i +: 4] = 4'(i + 1);
    return r;
  endfunction

  logic cand_legal;
  assign cand_legal = is_legal(cand);

  // Per-digit scoring for the digit selected by idx.
  logic [3:0] g_digit;
  logic [3:0] a_digit;
  logic       hit_strike;
  logic       hit_ball;
  logic [3:0] strikes_next;
  logic [3:0] balls_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    g_digit  = '0;
    a_digit  = '0;
    hit_ball = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        g_digit = g[4*i +: 4];
        a_digit = answer_q[4*i +: 4];
      end
    end
    hit_strike = (g_digit == a_digit);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) != idx && answer_q[4*i +: 4] == g_digit) hit_ball = !hit_strike;
    end
    strikes_next = strikes_q + {3'b000, hit_strike};
    balls_next   = balls_q + {3'b000, hit_ball};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      tries          <= '0;
      idx            <= '0;
      cand           <= '0;
      g              <= '0;
      answer_q       <= '0;
      fallback_q     <= 1'b0;
      result_valid_q <= 1'b0;
      strikes_q      <= '0;
      balls_q        <= '0;
      guesses_left_q <= '0;
      win_q          <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      result_valid_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.new_game) begin
            tries <= '0;
            state <= S_DRAW;
          end
        end

        S_DRAW: begin
          cand  <= bus.rand_in[W-1:0];
          tries <= tries + 8'd1;
          state <= S_CHECK;
        end

        S_CHECK: begin
          if (cand_legal || tries >= TRY_LIMIT) begin
            answer_q       <= cand_legal ? cand : default_answer();
            fallback_q     <= !cand_legal;
            guesses_left_q <= GUESS_LIMIT;
            strikes_q      <= '0;
            balls_q        <= '0;
            win_q          <= 1'b0;
            game_over_q    <= 1'b0;
            state          <= S_READY;
          end else begin
            state <= S_DRAW;
          end
        end

        S_READY: begin
          // A guess wins over a simultaneous restart request.
          if (bus.guess_valid) begin
            g         <= bus.guess;
            idx       <= '0;
            strikes_q <= '0;
            balls_q   <= '0;
            state     <= S_SCORE;
          end else if (bus.new_game) begin
            tries <= '0;
            state <= S_DRAW;
          end
        end

        S_SCORE: begin
          strikes_q <= strikes_next;
          balls_q   <= balls_next;
          if (idx == LAST_IDX) begin
            guesses_left_q <= (guesses_left_q != 4'd0) ? guesses_left_q - 4'd1 : 4'd0;
            win_q          <= (strikes_next == ALL_STRIKES);
            game_over_q    <= (strikes_next == ALL_STRIKES) || (guesses_left_q <= 4'd1);
            result_valid_q <= 1'b1;
            state          <= S_RESULT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_RESULT: begin
          state <= game_over_q ? S_DONE : S_READY;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state == S_DRAW) || (state == S_CHECK) ||
                            (state == S_SCORE) || (state == S_RESULT);
  assign bus.answer_valid = (state == S_READY) || (state == S_SCORE) ||
                            (state == S_RESULT) || (state == S_DONE);
  assign bus.answer       = answer_q;
  assign bus.fallback     = fallback_q;
  assign bus.result_valid = result_valid_q;
  assign bus.strikes      = strikes_q;
  assign bus.balls        = balls_q;
  assign bus.guesses_left = guesses_left_q;
  assign bus.win          = win_q;
  assign bus.game_over    = game_over_q;

endmodule
